// File: rtl/dmem_pkg.sv
// Shared encodings, FSM states and alignment helper for the data-memory responder.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_RESP
   } state_t;

   // Reserved size is folded in here so a single flag gates both write and read data.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      logic bad;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = addr_lo[0];
         SZ_WORD: bad = (addr_lo != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store mask/data replication and load extract/extend.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic [31:0] wdata,
   input  logic        is_unsigned,
   input  logic [31:0] rdata_raw,
   output logic [3:0]  wmask,
   output logic [31:0] wdata_aligned,
   output logic [31:0] rdata_ext
);

   logic [31:0] byte_shifted;
   logic [31:0] half_shifted;
   logic [7:0]  byte_val;
   logic [15:0] half_val;

   assign byte_shifted = rdata_raw >> {addr_lo, 3'b000};
   assign half_shifted = rdata_raw >> {addr_lo[1], 4'b0000};
   assign byte_val     = byte_shifted[7:0];
   assign half_val     = half_shifted[15:0];

   always_comb begin
      wmask         = 4'b0000;
      wdata_aligned = 32'h0;
      rdata_ext     = 32'h0;
      case (size)
         SZ_BYTE: begin
            wmask         = 4'b0001 << addr_lo;
            wdata_aligned = {4{wdata[7:0]}};
            rdata_ext     = {{24{~is_unsigned & byte_val[7]}}, byte_val};
         end
         SZ_HALF: begin
            wmask         = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata_aligned = {2{wdata[15:0]}};
            rdata_ext     = {{16{~is_unsigned & half_val[15]}}, half_val};
         end
         SZ_WORD: begin
            wmask         = 4'b1111;
            wdata_aligned = wdata;
            rdata_ext     = rdata_raw;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data memory behind valid/ready request and response channels,
// with sub-word access, load extension and misalignment reporting.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int    ADDR_W      = 16,
   parameter int    WAIT_CYCLES = 1,
   parameter string INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              we_reg;
   logic              unsigned_reg;
   logic [ADDR_W+1:0] addr_reg;
   logic [1:0]        size_reg;
   logic [31:0]       wdata_reg;
   logic [31:0]       rsp_rdata_reg;
   logic              rsp_err_reg;

   logic              accept;
   logic              access_err;
   logic              do_write;
   logic [ADDR_W-1:0] rd_idx;
   logic [ADDR_W-1:0] wr_idx;
   logic [31:0]       rd_word;
   logic [3:0]        wmask;
   logic [31:0]       wdata_aligned;
   logic [31:0]       rdata_ext;

   assign req_ready = (state_reg == ST_IDLE);
   assign rsp_valid = (state_reg == ST_RESP);
   assign rsp_rdata = rsp_rdata_reg;
   assign rsp_err   = rsp_err_reg;

   assign accept     = req_valid && (state_reg == ST_IDLE);
   assign access_err = is_misaligned(size_reg, addr_reg[1:0]);
   // Reset on the ACCESS exit edge means the access never completed: suppress the write.
   assign do_write   = (state_reg == ST_ACCESS) && we_reg && !access_err && !reset;
   assign wr_idx     = addr_reg[ADDR_W+1:2];
   // The array read is registered, so the word must be fetched on the acceptance edge
   // straight from the request address; afterwards the latched address is stable.
   assign rd_idx     = (state_reg == ST_IDLE) ? req_addr[ADDR_W+1:2] : addr_reg[ADDR_W+1:2];

   generate
      if (ADDR_W < 30) begin : g_addr_sink
         logic unused_addr_hi;
         assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
      end
   endgenerate

   dmem_lane_align u_align (
      .addr_lo       (addr_reg[1:0]),
      .size          (size_reg),
      .wdata         (wdata_reg),
      .is_unsigned   (unsigned_reg),
      .rdata_raw     (rd_word),
      .wmask         (wmask),
      .wdata_aligned (wdata_aligned),
      .rdata_ext     (rdata_ext)
   );

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] rd_byte_reg;

         always_ff @(posedge clk) begin
            if (do_write && wmask[gi]) begin
               mem[wr_idx] <= wdata_aligned[gi*8 +: 8];
            end
            rd_byte_reg <= mem[rd_idx];
         end

         assign rd_word[gi*8 +: 8] = rd_byte_reg;
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_IDLE: begin
            if (req_valid) begin
               cnt_next = CNT_LOAD;
               if (WAIT_CYCLES > 0) begin
                  state_next = ST_WAIT;
               end else begin
                  state_next = ST_ACCESS;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_reg == '0) begin
               state_next = ST_ACCESS;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         ST_ACCESS: state_next = ST_RESP;
         ST_RESP: begin
            if (rsp_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= '0;
         we_reg        <= 1'b0;
         unsigned_reg  <= 1'b0;
         addr_reg      <= '0;
         size_reg      <= SZ_BYTE;
         wdata_reg     <= 32'h0;
         rsp_rdata_reg <= 32'h0;
         rsp_err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (accept) begin
            we_reg       <= req_we;
            unsigned_reg <= req_unsigned;
            addr_reg     <= req_addr[ADDR_W+1:0];
            size_reg     <= req_size;
            wdata_reg    <= req_wdata;
         end
         if (state_reg == ST_ACCESS) begin
            rsp_err_reg   <= access_err;
            rsp_rdata_reg <= (we_reg || access_err) ? 32'h0 : rdata_ext;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances cover wait states, reset abort and aliasing.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_wdata;
   logic        rsp_ready;

   logic [2:0]  req_ready_w;
   logic [2:0]  rsp_valid_w;
   logic [2:0]  rsp_err_w;
   logic [31:0] rsp_rdata_w [3];
   logic [2:0]  valid_w;

   int sel = 0;
   int total = 0;
   int bad = 0;
   int txn_no = 0;
   int exp_lat [3] = '{2, 4, 1};

   logic [31:0] exp_d_q [$];
   logic        exp_e_q [$];
   logic [31:0] mon_d;
   logic        mon_e;

   always #5 clk = ~clk;

   assign valid_w[0] = req_valid && (sel == 0);
   assign valid_w[1] = req_valid && (sel == 1);
   assign valid_w[2] = req_valid && (sel == 2);

   dmem_responder #(.ADDR_W(16), .WAIT_CYCLES(1), .INIT_FILE("")) u_dut0 (
      .clk(clk), .reset(reset), .req_valid(valid_w[0]), .req_ready(req_ready_w[0]),
      .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata_w[0]), .rsp_err(rsp_err_w[0]));

   dmem_responder #(.ADDR_W(16), .WAIT_CYCLES(3), .INIT_FILE("")) u_dut1 (
      .clk(clk), .reset(reset), .req_valid(valid_w[1]), .req_ready(req_ready_w[1]),
      .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata_w[1]), .rsp_err(rsp_err_w[1]));

   dmem_responder #(.ADDR_W(4), .WAIT_CYCLES(0), .INIT_FILE("")) u_dut2 (
      .clk(clk), .reset(reset), .req_valid(valid_w[2]), .req_ready(req_ready_w[2]),
      .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid_w[2]), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata_w[2]), .rsp_err(rsp_err_w[2]));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Response side of the scoreboard: every handshake pops one expectation.
   always @(negedge clk) begin
      if (rsp_valid_w[sel] && rsp_ready) begin
         if (exp_d_q.size() == 0) begin
            check_val("unexpected_rsp", 32'd1, 32'd0);
         end else begin
            mon_d = exp_d_q.pop_front();
            mon_e = exp_e_q.pop_front();
            txn_no++;
            check_val("rsp_rdata", rsp_rdata_w[sel], mon_d);
            check_val("rsp_err", 32'(rsp_err_w[sel]), 32'(mon_e));
            $display("txn %0d inst=%0d rdata=%h err=%0b exp_rdata=%h exp_err=%0b",
                     txn_no, sel, rsp_rdata_w[sel], rsp_err_w[sel], mon_d, mon_e);
         end
      end
   end

   task automatic wait_accept(input int inst);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready_w[inst] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check_val("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      req_valid    = 1'b0;
      req_we       = 1'($urandom);
      req_addr     = $urandom;
      req_size     = 2'($urandom);
      req_unsigned = 1'($urandom);
      req_wdata    = $urandom;
   endtask

   task automatic do_txn(input int inst, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input logic [31:0] exp_d, input logic exp_e, input int hold);
      int lat;
      sel = inst;
      exp_d_q.push_back(exp_d);
      exp_e_q.push_back(exp_e);
      req_we       = we;
      req_addr     = addr;
      req_size     = size;
      req_unsigned = uns;
      req_wdata    = wdata;
      rsp_ready    = (hold == 0);
      req_valid    = 1'b1;
      wait_accept(inst);
      lat = 0;
      while (lat < 50) begin
         if (lat > 0) #1;
         lat++;
         @(posedge clk);
         #1;
         if (rsp_valid_w[inst]) break;
      end
      check_val("latency", 32'(lat), 32'(exp_lat[inst]));
      if (hold > 0) begin
         for (int k = 0; k < hold; k++) begin
            check_val("hold_valid", 32'(rsp_valid_w[inst]), 32'd1);
            check_val("hold_rdata", rsp_rdata_w[inst], exp_d);
            check_val("hold_err", 32'(rsp_err_w[inst]), 32'(exp_e));
            check_val("hold_req_ready", 32'(req_ready_w[inst]), 32'd0);
            @(posedge clk);
            #1;
         end
         rsp_ready = 1'b1;
         @(posedge clk);
         #1;
         check_val("req_ready_after_hs", 32'(req_ready_w[inst]), 32'd1);
      end else begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      reset        = 1'b1;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_addr     = 32'h0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_wdata    = 32'h0;
      rsp_ready    = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check_val("reset_req_ready", 32'(req_ready_w[i]), 32'd1);
         check_val("reset_rsp_valid", 32'(rsp_valid_w[i]), 32'd0);
         check_val("reset_rsp_rdata", rsp_rdata_w[i], 32'h0);
         check_val("reset_rsp_err", 32'(rsp_err_w[i]), 32'd0);
      end
      @(posedge clk);
      #1;

      // Word store/load, then sub-word stores and extension
      do_txn(0, 1'b1, 32'h100, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 0);
      do_txn(0, 1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 0);
      do_txn(0, 1'b1, 32'h101, 2'b00, 1'b0, 32'hFFFFFF80, 32'h0, 1'b0, 0);
      do_txn(0, 1'b1, 32'h106, 2'b01, 1'b0, 32'hABCD1234, 32'h0, 1'b0, 0);
      do_txn(0, 1'b0, 32'h100, 2'b10, 1'b1, 32'h0, 32'hDEAD80EF, 1'b0, 0);
      do_txn(0, 1'b0, 32'h101, 2'b00, 1'b0, 32'h0, 32'hFFFFFF80, 1'b0, 0);
      do_txn(0, 1'b0, 32'h101, 2'b00, 1'b1, 32'h0, 32'h00000080, 1'b0, 0);
      do_txn(0, 1'b0, 32'h106, 2'b01, 1'b0, 32'h0, 32'h00001234, 1'b0, 0);
      do_txn(0, 1'b0, 32'h102, 2'b01, 1'b0, 32'h0, 32'hFFFFDEAD, 1'b0, 0);
      do_txn(0, 1'b0, 32'h103, 2'b00, 1'b1, 32'h0, 32'h000000DE, 1'b0, 0);

      // Error cases leave memory untouched and return zero data
      do_txn(0, 1'b1, 32'h100, 2'b10, 1'b0, 32'h00000000, 32'h0, 1'b0, 0);
      do_txn(0, 1'b1, 32'h103, 2'b01, 1'b0, 32'h0000FFFF, 32'h0, 1'b1, 0);
      do_txn(0, 1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 32'h00000000, 1'b0, 0);
      do_txn(0, 1'b0, 32'h102, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 0);
      do_txn(0, 1'b0, 32'h100, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 0);
      do_txn(0, 1'b1, 32'h100, 2'b11, 1'b0, 32'h77777777, 32'h0, 1'b1, 0);
      do_txn(0, 1'b0, 32'h100, 2'b10, 1'b0, 32'h0, 32'h00000000, 1'b0, 0);

      // Response back-pressure
      do_txn(0, 1'b0, 32'h106, 2'b01, 1'b1, 32'h0, 32'h00001234, 1'b0, 5);

      // Reset during WAIT drops the pending store
      do_txn(1, 1'b1, 32'h200, 2'b10, 1'b0, 32'hAAAAAAAA, 32'h0, 1'b0, 0);
      sel          = 1;
      req_we       = 1'b1;
      req_addr     = 32'h200;
      req_size     = 2'b10;
      req_unsigned = 1'b0;
      req_wdata    = 32'h11111111;
      rsp_ready    = 1'b1;
      req_valid    = 1'b1;
      wait_accept(1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_val("abort_req_ready", 32'(req_ready_w[1]), 32'd1);
      check_val("abort_rsp_valid", 32'(rsp_valid_w[1]), 32'd0);
      repeat (6) @(posedge clk);
      #1;
      check_val("abort_no_rsp", 32'(rsp_valid_w[1]), 32'd0);
      do_txn(1, 1'b0, 32'h200, 2'b10, 1'b0, 32'h0, 32'hAAAAAAAA, 1'b0, 0);

      // Small array, no wait states: upper address bits alias
      do_txn(2, 1'b1, 32'h40, 2'b10, 1'b0, 32'h5A5A5A5A, 32'h0, 1'b0, 0);
      do_txn(2, 1'b0, 32'h00, 2'b10, 1'b0, 32'h0, 32'h5A5A5A5A, 1'b0, 0);
      do_txn(2, 1'b0, 32'h43, 2'b00, 1'b0, 32'h0, 32'h0000005A, 1'b0, 0);

      repeat (2) @(posedge clk);
      check_val("queue_empty", 32'(exp_d_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got=running expected=finished");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "timeout");
   end

endmodule
